project_engine: RTL and testbench

PROJECT_ENGINE -- requirements
Module: project_engine

---
 rtl/proj_pkg.sv | 19 +
 rtl/project_engine_if.sv | 28 ++
 rtl/recip_div.sv | 75 +++++++
 rtl/project_engine.sv | 189 ++++++++++++++++++
 tb/tb_project_engine.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/proj_pkg.sv
// Shared fixed-point types, state encoding and helpers for the projection engine.
package proj_pkg;
  localparam int WI_DEF = 8;
  localparam int WF_DEF = 8;
  localparam int FX_W   = WI_DEF + WF_DEF;

  typedef logic signed [FX_W-1:0] fx_t;
  typedef fx_t  [3:0] vec4_t;
  typedef vec4_t [3:0] mat4_t;

  localparam fx_t FX_ONE = fx_t'(1 << WF_DEF);

  typedef enum logic [2:0] {IDLE, MAC, RECIP, MAP, DONE} state_e;

  // Only the x, y and w rows of the MVP are used; local row 2 is matrix row 3.
  function automatic logic [1:0] mrow(input logic [1:0] r);
    return (r == 2'd2) ? 2'd3 : r;
  endfunction
endpackage

// File: rtl/project_engine_if.sv
// Handshake and data bundle between a triangle producer/consumer and project_engine.
interface project_engine_if #(
  parameter int WI    = 8,
  parameter int WF    = 8,
  parameter int OUT_W = 10
);
  localparam int W = WI + WF;

  logic                             mvp_load;
  logic [15:0][W-1:0]               mvp_in;
  logic                             mvp_ready;
  logic                             tri_valid;
  logic                             tri_ready;
  logic [2:0][2:0][W-1:0]           orig_triangle;
  logic                             out_valid;
  logic                             out_ready;
  logic [2:0][1:0][OUT_W-1:0]       proj_triangle;
  logic [2:0]                       tri_flags;

  modport slave (
    input  mvp_load, mvp_in, tri_valid, orig_triangle, out_ready,
    output mvp_ready, tri_ready, out_valid, proj_triangle, tri_flags
  );
  modport master (
    output mvp_load, mvp_in, tri_valid, orig_triangle, out_ready,
    input  mvp_ready, tri_ready, out_valid, proj_triangle, tri_flags
  );
endinterface

// File: rtl/recip_div.sv
// Sequential restoring divider producing 1/w in fixed point, one quotient bit per cycle.
module recip_div #(
  parameter int WI = 8,
  parameter int WF = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic signed [WI+WF-1:0] w_i,
  output logic                    done_o,
  output logic signed [WI+WF-1:0] rw_o
);
  localparam int W  = WI + WF;
  localparam int NB = WI + 2*WF;
  localparam int CW = $clog2(NB);
  localparam logic [CW-1:0] LAST    = CW'(NB-1);
  localparam logic [CW-1:0] ONE_BIT = CW'(WI-1);
  localparam logic [NB-1:0] QMAX    = NB'((1 << (W-1)) - 1);

  logic          busy_q, zero_q;
  logic [CW-1:0] cnt_q, idx;
  logic [W-1:0]  d_q, rem_q, d, rem_in, rem_d;
  logic [NB-1:0] quo_q, quo_in, quo_d;
  logic [W:0]    sh;
  logic          qbit;
  logic signed [W-1:0] rw_q;

  // Dividend is 1<<(2*WF): its single set bit is fed in at shift step WI-1.
  always_comb begin
    d      = d_q;
    rem_in = rem_q;
    idx    = cnt_q;
    quo_in = quo_q;
    if (start_i) begin
      d      = (w_i > 0) ? w_i : W'(1);
      rem_in = '0;
      idx    = '0;
      quo_in = '0;
    end
    sh    = {rem_in, (idx == ONE_BIT)};
    qbit  = (sh >= {1'b0, d});
    rem_d = qbit ? W'(sh - {1'b0, d}) : sh[W-1:0];
    quo_d = {quo_in[NB-2:0], qbit};
  end

  assign done_o = busy_q && (cnt_q == LAST);
  assign rw_o   = rw_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q <= 1'b0;
      zero_q <= 1'b0;
      cnt_q  <= '0;
      d_q    <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      rw_q   <= '0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      zero_q <= (w_i <= 0);
      cnt_q  <= CW'(1);
      d_q    <= d;
      rem_q  <= rem_d;
      quo_q  <= quo_d;
    end else if (busy_q) begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      cnt_q <= cnt_q + CW'(1);
      if (done_o) begin
        busy_q <= 1'b0;
        rw_q   <= zero_q ? '0 : (quo_d > QMAX) ? QMAX[W-1:0] : quo_d[W-1:0];
      end
    end
  end
endmodule

// File: rtl/project_engine.sv
// MVP transform + perspective divide + viewport map of one triangle per pass, single MAC.
// Define PROJ_CLIP_EN to clamp screen coordinates to the viewport and flag clamped vertices.
module project_engine
  import proj_pkg::*;
#(
  parameter int WI       = 8,
  parameter int WF       = 8,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480,
  parameter int OUT_W    = 10
) (
  input  logic             Clk,
  input  logic             Reset,
  project_engine_if.slave  bus
);
  localparam int W  = WI + WF;
  localparam int PW = 2*W;
  localparam int AW = PW + 2;
  localparam int MW = PW + 16;
  localparam logic signed [W-1:0]  ONE  = W'(1 << WF);
  localparam logic signed [AW-1:0] SMAX = AW'((1 << (W-1)) - 1);
  localparam logic signed [AW-1:0] SMIN = -SMAX - AW'(1);

  state_e      state_q, state_d;
  logic [1:0]  v_q, v_d;
  logic [3:0]  k_q, k_d;
  logic        ph_q, ph_d;

  logic [11:0][W-1:0]          mvp_q, work_q;
  logic [2:0][2:0][W-1:0]      vtx_q;
  logic signed [AW-1:0]        acc_q, acc_d, acc_sh;
  logic [2:0][W-1:0]           res_q;
  logic signed [PW-1:0]        xn_q, yn_q, xn_d, yn_d, prod;
  logic [2:0][1:0][OUT_W-1:0]  stage_q, proj_q;
  logic [2:0]                  sflag_q, flag_q;
  logic                        out_valid_q, start_q;
  logic signed [W-1:0]         coef, opnd, acc_sat, rw;
  logic signed [MW-1:0]        sxf, syf;
  logic [OUT_W-1:0]            sx, sy;
  logic [1:0]                  col;
  logic                        rdone, clip, wneg;

  recip_div #(.WI(WI), .WF(WF)) u_recip (
    .clk_i(Clk), .rst_i(Reset), .start_i(start_q),
    .w_i($signed(res_q[2])), .done_o(rdone), .rw_o(rw)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      v_q     <= '0;
      k_q     <= '0;
      ph_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      k_q     <= k_d;
      ph_q    <= ph_d;
    end
  end

  always_comb begin
    state_d = state_q;
    v_d     = v_q;
    k_d     = k_q;
    ph_d    = ph_q;
    case (state_q)
      IDLE:  if (bus.tri_valid) begin state_d = MAC; v_d = '0; k_d = '0; end
      MAC: begin
        k_d = k_q + 4'd1;
        if (k_q == 4'd11) begin k_d = '0; state_d = RECIP; end
      end
      RECIP: if (rdone) begin state_d = MAP; ph_d = 1'b0; end
      MAP: begin
        ph_d = ~ph_q;
        if (ph_q) begin
          if (v_q == 2'd2) state_d = DONE;
          else begin v_d = v_q + 2'd1; state_d = MAC; end
        end
      end
      DONE:  if (out_valid_q && bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // k_q walks row-major over the 12 used coefficients; column 3 multiplies the implied w=1.0.
  assign col = k_q[1:0];
  always_comb begin
    coef = work_q[k_q];
    case (col)
      2'd0:    opnd = vtx_q[v_q][0];
      2'd1:    opnd = vtx_q[v_q][1];
      2'd2:    opnd = vtx_q[v_q][2];
      default: opnd = ONE;
    endcase
    prod    = coef * opnd;
    acc_d   = (col == 2'd0) ? AW'(prod) : acc_q + AW'(prod);
    acc_sh  = acc_d >>> WF;
    acc_sat = (acc_sh > SMAX) ? SMAX[W-1:0] : (acc_sh < SMIN) ? SMIN[W-1:0] : acc_sh[W-1:0];
  end

  assign wneg = ($signed(res_q[2]) <= 0);
  assign xn_d = ($signed(res_q[0]) * rw) >>> WF;
  assign yn_d = ($signed(res_q[1]) * rw) >>> WF;
  assign sxf  = ((MW'(xn_q) + MW'(ONE)) * MW'(SCREEN_W)) >>> (WF+1);
  assign syf  = ((MW'(ONE) - MW'(yn_q)) * MW'(SCREEN_H)) >>> (WF+1);

`ifdef PROJ_CLIP_EN
  localparam logic signed [MW-1:0] XMAX = MW'(SCREEN_W-1);
  localparam logic signed [MW-1:0] YMAX = MW'(SCREEN_H-1);
  always_comb begin
    clip = 1'b0;
    sx   = sxf[OUT_W-1:0];
    sy   = syf[OUT_W-1:0];
    if (sxf < 0)         begin sx = '0; clip = 1'b1; end
    else if (sxf > XMAX) begin sx = OUT_W'(SCREEN_W-1); clip = 1'b1; end
    if (syf < 0)         begin sy = '0; clip = 1'b1; end
    else if (syf > YMAX) begin sy = OUT_W'(SCREEN_H-1); clip = 1'b1; end
  end
`else
  always_comb begin
    clip = 1'b0;
    sx   = sxf[OUT_W-1:0];
    sy   = syf[OUT_W-1:0];
  end
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < 12; i++)
        mvp_q[i] <= (mrow(2'(i/4)) == 2'(i%4)) ? ONE : '0;
      work_q      <= '0;
      vtx_q       <= '0;
      acc_q       <= '0;
      res_q       <= '0;
      xn_q        <= '0;
      yn_q        <= '0;
      stage_q     <= '0;
      sflag_q     <= '0;
      proj_q      <= '0;
      flag_q      <= '0;
      out_valid_q <= 1'b0;
      start_q     <= 1'b0;
    end else begin
      start_q <= (state_q == MAC) && (state_d == RECIP);
      case (state_q)
        IDLE: begin
          // The accepted triangle snapshots the matrix held before any same-cycle load.
          if (bus.mvp_load)
            for (int i = 0; i < 12; i++)
              mvp_q[i] <= bus.mvp_in[{mrow(2'(i/4)), 2'(i%4)}];
          if (bus.tri_valid) begin
            vtx_q  <= bus.orig_triangle;
            work_q <= mvp_q;
          end
        end
        MAC: begin
          acc_q <= acc_d;
          if (col == 2'd3) res_q[k_q[3:2]] <= acc_sat;
        end
        MAP: begin
          if (!ph_q) begin
            xn_q <= xn_d;
            yn_q <= yn_d;
          end else begin
            stage_q[v_q] <= {sy, sx};
            sflag_q[v_q] <= wneg | clip;
          end
        end
        DONE: begin
          if (!out_valid_q) begin
            proj_q      <= stage_q;
            flag_q      <= sflag_q;
            out_valid_q <= 1'b1;
          end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.mvp_ready     = (state_q == IDLE);
  assign bus.tri_ready     = (state_q == IDLE);
  assign bus.out_valid     = out_valid_q;
  assign bus.proj_triangle = proj_q;
  assign bus.tri_flags     = flag_q;
endmodule

// File: tb/tb_project_engine.sv
// Randomized self-checking bench for project_engine against an arithmetic reference model.
module tb_project_engine;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  project_engine_if ifc();
  project_engine dut (.Clk(clk), .Reset(rst), .bus(ifc));

  int n_tests = 0;
  int n_fail  = 0;
  int held_m[16];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic longint fdiv(input longint a, input longint b);
    longint q;
    q = a / b;
    if ((a % b != 0) && ((a < 0) != (b < 0))) q = q - 1;
    return q;
  endfunction

  // Reference: rows x,y,w of held matrix, floor to Q8.8, saturate, 1/w, viewport map.
  task automatic model_vtx(input int x, input int y, input int z,
                           output logic [9:0] sx, output logic [9:0] sy, output logic fl);
    longint v[4];
    longint r[3];
    longint rw, xn, yn, px, py;
    int rows[3];
    rows = '{0, 1, 3};
    v = '{longint'(x), longint'(y), longint'(z), 256};
    for (int i = 0; i < 3; i++) begin
      r[i] = 0;
      for (int c = 0; c < 4; c++) r[i] += longint'(held_m[rows[i]*4+c]) * v[c];
      r[i] = fdiv(r[i], 256);
      if (r[i] > 32767)  r[i] = 32767;
      if (r[i] < -32768) r[i] = -32768;
    end
    fl = (r[2] <= 0);
    rw = fl ? 0 : 65536 / r[2];
    if (rw > 32767) rw = 32767;
    xn = fdiv(r[0] * rw, 256);
    yn = fdiv(r[1] * rw, 256);
    px = fdiv((xn + 256) * 640, 512);
    py = fdiv((256 - yn) * 480, 512);
`ifdef PROJ_CLIP_EN
    if (px < 0)   begin px = 0;   fl = 1'b1; end
    if (px > 639) begin px = 639; fl = 1'b1; end
    if (py < 0)   begin py = 0;   fl = 1'b1; end
    if (py > 479) begin py = 479; fl = 1'b1; end
`endif
    sx = 10'(px);
    sy = 10'(py);
  endtask

  task automatic model_tri(input int t[9], output logic [59:0] p, output logic [2:0] f);
    logic [9:0] sx, sy;
    logic fv;
    for (int vv = 0; vv < 3; vv++) begin
      model_vtx(t[vv*3], t[vv*3+1], t[vv*3+2], sx, sy, fv);
      p[vv*20 +: 20] = {sy, sx};
      f[vv] = fv;
    end
  endtask

  task automatic load_mvp(input int m[16]);
    for (int i = 0; i < 16; i++) ifc.mvp_in[i] = 16'(m[i]);
    ifc.mvp_load = 1'b1;
    @(posedge clk); #1;
    ifc.mvp_load = 1'b0;
    held_m = m;
  endtask

  // Accept one triangle and wait for out_valid; optionally pulse mvp_load mid-flight
  // (poke >= 0) or together with the accept (same_load).
  task automatic send_tri(input int t[9], input int poke, input bit same_load, input int newm[16]);
    logic [59:0] ep;
    logic [2:0]  ef;
    int lat;
    model_tri(t, ep, ef);
    for (int vv = 0; vv < 3; vv++)
      for (int c = 0; c < 3; c++) ifc.orig_triangle[vv][c] = 16'(t[vv*3+c]);
    ifc.tri_valid = 1'b1;
    if (same_load) begin
      for (int i = 0; i < 16; i++) ifc.mvp_in[i] = 16'(newm[i]);
      ifc.mvp_load = 1'b1;
    end
    chk("tri_ready_idle", ifc.tri_ready, 1);
    @(posedge clk); #1;
    ifc.tri_valid = 1'b0;
    ifc.mvp_load  = 1'b0;
    if (same_load) held_m = newm;
    lat = 0;
    while (!ifc.out_valid && lat < 400) begin
      if (lat == poke) begin
        for (int i = 0; i < 16; i++) ifc.mvp_in[i] = 16'(newm[i]);
        ifc.mvp_load = 1'b1;
      end
      @(posedge clk); #1;
      ifc.mvp_load = 1'b0;
      lat++;
      if (lat == 60) chk("busy_tri_ready", ifc.tri_ready, 0);
    end
    chk("latency", lat, 115);
    chk("proj", ifc.proj_triangle, ep);
    chk("flags", ifc.tri_flags, ef);
  endtask

  task automatic hs();
    ifc.out_ready = 1'b1;
    @(posedge clk); #1;
    ifc.out_ready = 1'b0;
    chk("out_valid_clear", ifc.out_valid, 0);
  endtask

  initial begin
    int t[9];
    int ident[16], ma[16], mb[16], mr[16];
    logic [59:0] e39, hp;
    int seen;

    for (int i = 0; i < 16; i++) ident[i] = (i % 5 == 0) ? 256 : 0;
    held_m = ident;
    ifc.mvp_load = 1'b0;
    ifc.mvp_in = '0;
    ifc.tri_valid = 1'b0;
    ifc.orig_triangle = '0;
    ifc.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_out_valid", ifc.out_valid, 0);
    chk("rst_proj", ifc.proj_triangle, 0);
    chk("rst_flags", ifc.tri_flags, 0);
    chk("rst_tri_ready", ifc.tri_ready, 1);
    chk("rst_mvp_ready", ifc.mvp_ready, 1);

    // Reference triangle with the reset (identity) matrix
    t = '{0, 0, 0, 128, 0, 0, -256, 256, 0};
    send_tri(t, -1, 1'b0, ident);
    e39 = {10'd0, 10'd0, 10'd240, 10'd480, 10'd240, 10'd320};
    chk("ref_tri_proj", ifc.proj_triangle, e39);
    chk("ref_tri_flags", ifc.tri_flags, 0);
    hs();

    // x = 2.0 lands off-screen
    t = '{512, 0, 0, 0, 0, 0, 0, 0, 0};
    send_tri(t, -1, 1'b0, ident);
`ifdef PROJ_CLIP_EN
    chk("x2_sx", ifc.proj_triangle[0][0], 639);
    chk("x2_flag", ifc.tri_flags[0], 1);
`else
    chk("x2_sx", ifc.proj_triangle[0][0], 960);
    chk("x2_flag", ifc.tri_flags[0], 0);
`endif
    hs();

    // w row zero: every vertex flagged and mapped through rw = 0
    ma = ident;
    ma[15] = 0;
    load_mvp(ma);
    t = '{100, -50, 30, 300, 200, -10, -400, 77, 5};
    send_tri(t, -1, 1'b0, ident);
    chk("w0_flags", ifc.tri_flags, 3'b111);
    e39 = {10'd240, 10'd320, 10'd240, 10'd320, 10'd240, 10'd320};
    chk("w0_proj", ifc.proj_triangle, e39);
    hs();
    load_mvp(ident);

    // Back-pressure in DONE, then back-to-back accept
    t = '{64, -32, 0, -100, 90, 10, 200, 200, 0};
    send_tri(t, -1, 1'b0, ident);
    hp = ifc.proj_triangle;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("hold_proj", ifc.proj_triangle, hp);
      chk("hold_tri_ready", ifc.tri_ready, 0);
      chk("hold_valid", ifc.out_valid, 1);
    end
    t = '{-64, 32, 0, 10, -90, 0, 0, 128, 0};
    for (int vv = 0; vv < 3; vv++)
      for (int c = 0; c < 3; c++) ifc.orig_triangle[vv][c] = 16'(t[vv*3+c]);
    ifc.tri_valid = 1'b1;
    ifc.out_ready = 1'b1;
    @(posedge clk); #1;
    ifc.out_ready = 1'b0;
    chk("b2b_idle", ifc.tri_ready, 1);
    chk("b2b_valid_drop", ifc.out_valid, 0);
    send_tri(t, -1, 1'b0, ident);
    hs();

    // mvp_load during MAC is ignored; a load alongside an accept applies to the next triangle
    ma = ident;
    ma[0] = 512; ma[7] = 64;
    load_mvp(ma);
    mb = ident;
    mb[5] = 384; mb[3] = -128; mb[15] = 512;
    t = '{100, 100, 0, -50, 20, 0, 30, -70, 0};
    send_tri(t, 3, 1'b0, mb);
    hs();
    send_tri(t, -1, 1'b1, mb);
    hs();
    send_tri(t, -1, 1'b0, ident);
    hs();

    // Randomized matrices and vertices
    for (int n = 0; n < 14; n++) begin
      for (int i = 0; i < 16; i++) mr[i] = int'($urandom_range(0, 767)) - 384;
      if (n % 2 == 0) mr[15] = int'($urandom_range(128, 512));
      load_mvp(mr);
      for (int i = 0; i < 9; i++) t[i] = int'($urandom_range(0, 1023)) - 512;
      send_tri(t, -1, 1'b0, ident);
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      hs();
    end

    // Reset in the middle of a triangle
    load_mvp(mb);
    t = '{128, 128, 0, 0, 0, 0, 64, 64, 0};
    for (int vv = 0; vv < 3; vv++)
      for (int c = 0; c < 3; c++) ifc.orig_triangle[vv][c] = 16'(t[vv*3+c]);
    ifc.tri_valid = 1'b1;
    @(posedge clk); #1;
    ifc.tri_valid = 1'b0;
    repeat (49) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_valid", ifc.out_valid, 0);
    chk("midrst_tri_ready", ifc.tri_ready, 1);
    chk("midrst_mvp_ready", ifc.mvp_ready, 1);
    chk("midrst_proj", ifc.proj_triangle, 0);
    @(posedge clk); #1 rst = 1'b0;
    held_m = ident;
    seen = 0;
    for (int i = 0; i < 150; i++) begin
      @(posedge clk); #1;
      if (ifc.out_valid) seen++;
    end
    chk("no_stale_out", seen, 0);
    t = '{128, 0, 0, 0, 128, 0, -128, -128, 0};
    send_tri(t, -1, 1'b0, ident);
    hs();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
